// File: rtl/emit_heartbeat.sv
// Heartbeat frame transmitter: builds SYNC/seq/status/chk frames on a period timer or
// a start pulse and serialises them onto a valid/ready byte stream.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for a pending or start trigger; launch captures the frame
// SEND       | presenting frame bytes 0..4, advancing on tx_valid && tx_ready
// DONE_STATE | one-cycle done pulse; sequence number and frame count advance
module emit_heartbeat #(
   parameter int unsigned PERIOD    = 1000,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        start,
   input  logic [7:0]  status_in,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        done,
   output logic [15:0] seq_out,
   output logic [31:0] result
);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      DONE_STATE
   } state_e;

   localparam logic [31:0] TIMER_TC  = 32'(PERIOD - 1);
   localparam logic [2:0]  LAST_BYTE = 3'd4;

   state_e      state_q;
   logic [2:0]  byte_idx_q;
   logic [7:0]  stat_buf_q;
   logic [15:0] seq_buf_q;
   logic [7:0]  chk_buf_q;
   logic [7:0]  tx_data_q;
   logic        tx_valid_q;
   logic        done_q;

   logic [31:0] timer_q,   timer_d;
   logic        pending_q, pending_d;
   logic [15:0] seq_q,     seq_d;
   logic [31:0] result_q,  result_d;

   logic        expire;
   logic        trigger;
   logic        launch;
   logic        accept;
   logic [7:0]  chk_new;
   logic [7:0]  next_byte;

   always_comb begin
      expire  = enable && (timer_q == TIMER_TC);
      trigger = start || expire;
      launch  = (state_q == IDLE) && (pending_q || start);
      accept  = tx_valid_q && tx_ready;
      chk_new = SYNC_BYTE ^ seq_q[15:8] ^ seq_q[7:0] ^ status_in;

      timer_d = timer_q + 32'd1;
      if (!enable || expire) begin
         timer_d = '0;
      end

      // A launch consumes the pending request; a start that itself causes the
      // launch is consumed too, but any other trigger that cycle stays pending.
      pending_d = pending_q || trigger;
      if (launch) begin
         pending_d = pending_q ? trigger : expire;
      end

      seq_d    = seq_q;
      result_d = result_q;
      if (state_q == DONE_STATE) begin
         seq_d    = seq_q + 16'd1;
         result_d = result_q + 32'd1;
      end

      next_byte = chk_buf_q;
      case (byte_idx_q)
         3'd0:    next_byte = seq_buf_q[15:8];
         3'd1:    next_byte = seq_buf_q[7:0];
         3'd2:    next_byte = stat_buf_q;
         default: next_byte = chk_buf_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q   <= '0;
         pending_q <= 1'b0;
         seq_q     <= '0;
         result_q  <= '0;
      end else begin
         timer_q   <= timer_d;
         pending_q <= pending_d;
         seq_q     <= seq_d;
         result_q  <= result_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         byte_idx_q <= '0;
         stat_buf_q <= '0;
         seq_buf_q  <= '0;
         chk_buf_q  <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (launch) begin
                  stat_buf_q <= status_in;
                  seq_buf_q  <= seq_q;
                  chk_buf_q  <= chk_new;
                  byte_idx_q <= '0;
                  tx_data_q  <= SYNC_BYTE;
                  tx_valid_q <= 1'b1;
                  state_q    <= SEND;
               end
            end
            SEND: begin
               if (accept) begin
                  if (byte_idx_q == LAST_BYTE) begin
                     tx_valid_q <= 1'b0;
                     done_q     <= 1'b1;
                     state_q    <= DONE_STATE;
                  end else begin
                     byte_idx_q <= byte_idx_q + 3'd1;
                     tx_data_q  <= next_byte;
                  end
               end
            end
            DONE_STATE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               tx_valid_q <= 1'b0;
               done_q     <= 1'b0;
               state_q    <= IDLE;
            end
         endcase
      end
   end

   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign done     = done_q;
   assign seq_out  = seq_q;
   assign result   = result_q;

endmodule

// File: tb/tb_emit_heartbeat.sv
// Self-checking bench for emit_heartbeat: scoreboard of expected frame bytes popped on
// every accepted byte, plus per-scenario latency, stall, timer and reset checks.
module tb_emit_heartbeat;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        start;
   logic [7:0]  status_in;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        done;
   logic [15:0] seq_out;
   logic [31:0] result;

   int          checks   = 0;
   int          failures = 0;
   logic [7:0]  exp_q[$];
   logic [15:0] m_seq    = 16'h0000;
   logic [31:0] m_result = 32'h0;

   emit_heartbeat #(.PERIOD(8), .SYNC_BYTE(8'hA5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .start     (start),
      .status_in (status_in),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .done      (done),
      .seq_out   (seq_out),
      .result    (result)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input logic [7:0] st);
      logic [7:0] chk;
      chk = 8'hA5 ^ m_seq[15:8] ^ m_seq[7:0] ^ st;
      exp_q.push_back(8'hA5);
      exp_q.push_back(m_seq[15:8]);
      exp_q.push_back(m_seq[7:0]);
      exp_q.push_back(st);
      exp_q.push_back(chk);
      m_seq    = m_seq + 16'd1;
      m_result = m_result + 32'd1;
   endtask

   task automatic pulse_start(input logic [7:0] st);
      step();
      start     = 1'b1;
      status_in = st;
      step();
      start     = 1'b0;
   endtask

   task automatic monitor();
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && tx_valid && tx_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected tx_data=%h but no byte expected", tx_data);
            end else begin
               e = exp_q.pop_front();
               if (tx_data !== e) begin
                  failures++;
                  $display("FAIL sb_byte tx_data=%h expected=%h", tx_data, e);
               end
            end
         end
      end
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL %s_done_timeout done=%b expected=1 within 40 cycles", name, done);
      end
   endtask

   task automatic check_counters(input string name);
      @(negedge clk);
      checks++;
      if (seq_out !== m_seq) begin
         failures++;
         $display("FAIL %s_seq seq_out=%h expected=%h", name, seq_out, m_seq);
      end
      checks++;
      if (result !== m_result) begin
         failures++;
         $display("FAIL %s_result result=%0d expected=%0d", name, result, m_result);
      end
   endtask

   task automatic check_drained(input string name);
      int busy;
      busy = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (tx_valid !== 1'b0) busy++;
      end
      checks++;
      if (busy != 0 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_drain valid_cycles=%0d left_bytes=%0d expected=0/0",
                  name, busy, exp_q.size());
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({tx_data, tx_valid, done} !== 10'h0) begin
         failures++;
         $display("FAIL reset_tx tx_data=%h tx_valid=%b done=%b expected=00/0/0",
                  tx_data, tx_valid, done);
      end
      checks++;
      if (seq_out !== 16'h0 || result !== 32'h0) begin
         failures++;
         $display("FAIL reset_cnt seq_out=%h result=%0d expected=0/0", seq_out, result);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      logic exp_v, exp_d;
      push_frame(8'h3C);
      pulse_start(8'h3C);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         exp_v = (k <= 5);
         exp_d = (k == 6);
         checks++;
         if (tx_valid !== exp_v || done !== exp_d) begin
            failures++;
            $display("FAIL single_latency cycle=N+%0d valid=%b done=%b expected=%b/%b",
                     k, tx_valid, done, exp_v, exp_d);
         end
      end
      check_counters("single");
   endtask

   task automatic test_second();
      push_frame(8'h3C);
      pulse_start(8'h3C);
      status_in = 8'hFF;
      wait_done("second");
      check_counters("second");
      status_in = 8'h00;
   endtask

   task automatic test_stall();
      push_frame(8'h5A);
      pulse_start(8'h5A);
      step();
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin
            failures++;
            $display("FAIL stall_hold cycle=%0d valid=%b data=%h expected=1/00",
                     i, tx_valid, tx_data);
         end
      end
      step();
      tx_ready = 1'b1;
      wait_done("stall");
      check_counters("stall");
   endtask

   task automatic test_timer();
      int starts[3];
      int nf;
      logic prev_v;
      nf     = 0;
      prev_v = 1'b0;
      status_in = 8'h11;
      for (int i = 0; i < 3; i++) push_frame(8'h11);
      step();
      enable = 1'b1;
      for (int c = 0; c < 120 && nf < 3; c++) begin
         @(negedge clk);
         if (tx_valid && !prev_v) begin
            starts[nf] = c;
            nf++;
         end
         prev_v = tx_valid;
      end
      step();
      enable = 1'b0;
      checks++;
      if (nf != 3) begin
         failures++;
         $display("FAIL timer_frames seen=%0d expected=3", nf);
      end else begin
         checks++;
         if (starts[1] - starts[0] != 8 || starts[2] - starts[1] != 8) begin
            failures++;
            $display("FAIL timer_period gaps=%0d,%0d expected=8,8",
                     starts[1] - starts[0], starts[2] - starts[1]);
         end
      end
      wait_done("timer");
      check_counters("timer");
      check_drained("timer");
   endtask

   task automatic test_coalesce();
      push_frame(8'h22);
      push_frame(8'h22);
      pulse_start(8'h22);
      start = 1'b1; step();
      start = 1'b0; step();
      start = 1'b1; step();
      start = 1'b0; step();
      start = 1'b1; step();
      start = 1'b0;
      wait_done("coalesce1");
      wait_done("coalesce2");
      check_counters("coalesce");
      check_drained("coalesce");
   endtask

   task automatic test_wrap();
      @(negedge clk);
      force dut.seq_q = 16'hFFFF;
      step();
      release dut.seq_q;
      m_seq = 16'hFFFF;
      @(negedge clk);
      checks++;
      if (seq_out !== 16'hFFFF) begin
         failures++;
         $display("FAIL wrap_preload seq_out=%h expected=ffff", seq_out);
      end
      push_frame(8'h44);
      pulse_start(8'h44);
      wait_done("wrap");
      check_counters("wrap");
   endtask

   task automatic test_reset_mid();
      int dn;
      dn = 0;
      push_frame(8'h55);
      pulse_start(8'h55);
      step();
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (tx_valid !== 1'b0) begin
         failures++;
         $display("FAIL midrst_valid tx_valid=%b expected=0", tx_valid);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done !== 1'b0) dn++;
      end
      checks++;
      if (dn != 0) begin
         failures++;
         $display("FAIL midrst_done done_cycles=%0d expected=0", dn);
      end
      exp_q.delete();
      m_seq    = 16'h0;
      m_result = 32'h0;
      rst_n    = 1'b1;
      check_counters("midrst_clear");
      push_frame(8'h55);
      pulse_start(8'h55);
      wait_done("midrst");
      check_counters("midrst");
      check_drained("midrst");
   endtask

   initial begin
      rst_n     = 1'b0;
      enable    = 1'b0;
      start     = 1'b0;
      status_in = 8'h00;
      tx_ready  = 1'b1;
      fork
         monitor();
      join_none
      test_reset();
      test_single();
      test_second();
      test_stall();
      test_timer();
      test_coalesce();
      test_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
